load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's memory stage and the byte-addressed unified MEMORY block (data port).
//  Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory accesses.
//  Sub-word stores use read-modify-write, because MEMORY always writes 4 bytes.
//  Loads are lane-selected and sign/zero-extended. Misaligned or illegal requests are flagged and never touch memory.
// PARAMETERS
//  none (XLEN fixed at 32)
// PORTS
//  SYS_clk            in   1   clock; all state changes on rising edge
//  SYS_reset          in   1   synchronous, active-high reset
//  LSU_req_valid      in   1   request offered
//  LSU_req_ready      out  1   LSU can accept; high only in IDLE
//  LSU_req_write      in   1   1=store, 0=load
//  LSU_req_funct3     in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  LSU_req_address    in   32  byte address
//  LSU_req_wdata      in   32  store data (low bits used for B/H)
//  LSU_resp_valid     out  1   response available; held until LSU_resp_ready
//  LSU_resp_ready     in   1   consumer takes response
//  LSU_resp_rdata     out  32  load result (0 for stores and errors)
//  LSU_resp_misaligned out 1   request rejected (misaligned or illegal funct3)
//  MEM_read_address   out  32  to MEMORY; {addr_q[31:2],2'b00}
//  MEM_read_data      in   32  from MEMORY; combinational read
//  MEM_write_enable   out  1   to MEMORY; high exactly one cycle per store
//  MEM_write_address  out  32  to MEMORY; {addr_q[31:2],2'b00}
//  MEM_write_data     out  32  to MEMORY; merged word
// BEHAVIOUR
//  Request handshake: a request is accepted when LSU_req_valid & LSU_req_ready at a clock edge.
//  On accept, the LSU latches addr_q, wdata_q, funct3_q and write_q. One request is in flight at a time.
//  FSM states: IDLE, RD, WR, RESP. State encodings are registered, and all outputs are decodes of registers.
//  Transitions out of IDLE on accept:
//   - error -> RESP with misaligned=1. Error means: funct3 in {011,110,111}; H/HU/SH with addr[0]=1;
//     W/SW with addr[1:0]!=0; store with funct3 in {100,101}.
//   - load  -> RD
//   - SW    -> WR
//   - SB/SH -> RD
//  Transitions out of RD:
//   - load: extract the lane from MEM_read_data, register it into rdata_q, go to RESP.
//   - SB/SH: merge into MEM_read_data and register the result into wdata_q, go to WR.
//  Transitions out of WR: MEM_write_enable=1 this cycle only, go to RESP.
//  Transitions out of RESP: LSU_resp_valid=1; go to IDLE when LSU_resp_ready=1.
//   - Response outputs stay stable while waiting.
//   - No new request is accepted in the same cycle as the response handshake.
//  Latency (accept edge = cycle 0; resp_valid first high in cycle n):
//   - error: n=1
//   - load: n=2
//   - SW: n=2
//   - SB/SH: n=3
//  Load extract, with lane = addr_q[1:0]:
//   - LB:  sign-extend byte[lane]
//   - LBU: zero-extend byte[lane]
//   - LH:  sign-extend half[addr_q[1]]
//   - LHU: zero-extend half[addr_q[1]]
//   - LW:  full word
//  Store merge:
//   - SB replaces only byte[lane] with wdata[7:0].
//   - SH replaces half[addr_q[1]] with wdata[15:0].
//   - SW writes wdata unchanged.
//  MEM_read_address and MEM_write_address always show the aligned addr_q; low 2 bits are always 00.
//  MEM_write_data = wdata_q (after merge for SB/SH).
//  Address wrap: 0xFFFFFFFC is a legal word address; there is no carry past bit 31.
//  Reset values:
//   - state=IDLE, LSU_req_ready=1
//   - LSU_resp_valid=0, LSU_resp_rdata=0, LSU_resp_misaligned=0
//   - MEM_write_enable=0, MEM_*_address=0, MEM_write_data=0
//  Reset mid-operation: the FSM goes to IDLE at the reset edge, and any pending RD/WR/RESP is discarded.
//   If reset is high during WR, the write is dropped (MEMORY also ignores writes while SYS_reset=1).
// TESTING
//  1. Hold reset 2 cycles, release -> all outputs 0, LSU_req_ready=1, no MEM_write_enable.
//  2. SW 0x100, wdata 0xDEADBEEF
//     -> cycle 1: MEM_write_enable=1, addr 0x100, data 0xDEADBEEF
//     -> cycle 2: resp_valid, rdata 0
//  3. mem[0x100]=0x11223344; SB 0x103, wdata 0x000000AA
//     -> cycle 2: write 0xAA223344 to 0x100
//     -> resp at cycle 3; other bytes unchanged
//  4. mem[0x100]=0x11803344:
//     -> LB 0x102 -> 0xFFFFFF80
//     -> LBU 0x102 -> 0x00000080
//     -> LH 0x102 -> 0x00001180
//     -> LW 0x100 -> 0x11803344
//     -> each with resp at cycle 2
//  5. SH 0x101 and LW 0x102 -> misaligned=1 at cycle 1, rdata 0, MEM_write_enable never high.
//     funct3=011 -> also misaligned.
//  6. LSU_resp_ready low 3 cycles -> resp outputs stable, LSU_req_ready=0.
//     Assert reset during WR of an SB -> no write committed, FSM back in IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the core's memory stage to a byte-addressed memory whose data port
//   always reads and writes whole 32-bit words. Sub-word stores are turned into
//   a read-modify-write sequence. Load results are lane-selected and then sign-
//   or zero-extended. A misaligned or illegal request is answered with an error
//   flag and never reaches memory.
//
// Ports
//   SYS_clk, SYS_reset       clock, synchronous active-high reset
//   LSU_req_*                request channel (valid/ready, write, funct3, address, wdata)
//   LSU_resp_*               response channel (valid/ready, rdata, misaligned)
//   MEM_read_address/data    word-aligned read port (combinational read data)
//   MEM_write_*              word-aligned write port, enable pulses one cycle per store
module load_store_unit (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        LSU_req_valid,
    output logic        LSU_req_ready,
    input  logic        LSU_req_write,
    input  logic [2:0]  LSU_req_funct3,
    input  logic [31:0] LSU_req_address,
    input  logic [31:0] LSU_req_wdata,
    output logic        LSU_resp_valid,
    input  logic        LSU_resp_ready,
    output logic [31:0] LSU_resp_rdata,
    output logic        LSU_resp_misaligned,
    output logic [31:0] MEM_read_address,
    input  logic [31:0] MEM_read_data,
    output logic        MEM_write_enable,
    output logic [31:0] MEM_write_address,
    output logic [31:0] MEM_write_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        misaligned_q;

    logic        req_error_d;
    logic [31:0] load_value_d;
    logic [31:0] merged_d;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Classify the offered request; only meaningful while in IDLE.
    always_comb begin
        req_error_d = 1'b0;
        case (LSU_req_funct3)
            3'b000:  req_error_d = 1'b0;
            3'b001:  req_error_d = LSU_req_address[0];
            3'b010:  req_error_d = |LSU_req_address[1:0];
            3'b100:  req_error_d = LSU_req_write;
            3'b101:  req_error_d = LSU_req_write | LSU_req_address[0];
            default: req_error_d = 1'b1;
        endcase
    end

    // Load extraction from the word currently returned by memory.
    always_comb begin
        lane_byte    = MEM_read_data[{addr_q[1:0], 3'b000} +: 8];
        lane_half    = addr_q[1] ? MEM_read_data[31:16] : MEM_read_data[15:0];
        load_value_d = MEM_read_data;
        case (funct3_q)
            3'b000:  load_value_d = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_value_d = {24'd0, lane_byte};
            3'b001:  load_value_d = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_value_d = {16'd0, lane_half};
            default: load_value_d = MEM_read_data;
        endcase
    end

    // Store merge: each byte lane either keeps the memory byte or takes the
    // store byte. For SH the store byte for lane gi is wdata[8*(gi%2) +: 8].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            logic lane_we;
            logic [7:0] lane_src;
            assign lane_we  = (funct3_q[1:0] == 2'b00) ? (addr_q[1:0] == gi[1:0])
                                                       : (addr_q[1] == gi[1]);
            assign lane_src = (funct3_q[1:0] == 2'b00) ? wdata_q[7:0]
                                                       : wdata_q[8*(gi%2) +: 8];
            assign merged_d[8*gi +: 8] = lane_we ? lane_src : MEM_read_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            funct3_q     <= 3'd0;
            write_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (LSU_req_valid) begin
                        addr_q       <= LSU_req_address;
                        wdata_q      <= LSU_req_wdata;
                        funct3_q     <= LSU_req_funct3;
                        write_q      <= LSU_req_write;
                        rdata_q      <= 32'd0;
                        misaligned_q <= req_error_d;
                        if (req_error_d) begin
                            state_q <= S_RESP;
                        end else if (LSU_req_write && LSU_req_funct3 == 3'b010) begin
                            // Full-word store needs no read of the old word.
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (write_q) begin
                        wdata_q <= merged_d;
                        state_q <= S_WR;
                    end else begin
                        rdata_q <= load_value_d;
                        state_q <= S_RESP;
                    end
                end
                S_WR: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (LSU_resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign LSU_req_ready       = (state_q == S_IDLE);
    assign LSU_resp_valid      = (state_q == S_RESP);
    assign LSU_resp_rdata      = rdata_q;
    assign LSU_resp_misaligned = misaligned_q;
    assign MEM_write_enable    = (state_q == S_WR);
    assign MEM_read_address    = {addr_q[31:2], 2'b00};
    assign MEM_write_address   = {addr_q[31:2], 2'b00};
    assign MEM_write_data      = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        LSU_req_valid = 1'b0;
    logic        LSU_req_ready;
    logic        LSU_req_write = 1'b0;
    logic [2:0]  LSU_req_funct3 = 3'd0;
    logic [31:0] LSU_req_address = 32'd0;
    logic [31:0] LSU_req_wdata = 32'd0;
    logic        LSU_resp_valid;
    logic        LSU_resp_ready = 1'b1;
    logic [31:0] LSU_resp_rdata;
    logic        LSU_resp_misaligned;
    logic [31:0] MEM_read_address;
    logic [31:0] MEM_read_data;
    logic        MEM_write_enable;
    logic [31:0] MEM_write_address;
    logic [31:0] MEM_write_data;

    int total = 0;
    int bad = 0;

    // Behavioural memory: 256 words, indexed by address bits [9:2].
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = 32'd0;
    logic [31:0] pre_data = 32'd0;

    always #5 SYS_clk = ~SYS_clk;

    always @(posedge SYS_clk) begin
        if (pre_en)
            mem[pre_addr[9:2]] <= pre_data;
        else if (MEM_write_enable && !SYS_reset)
            mem[MEM_write_address[9:2]] <= MEM_write_data;
    end

    assign MEM_read_data = mem[MEM_read_address[9:2]];

    load_store_unit dut (
        .SYS_clk            (SYS_clk),
        .SYS_reset          (SYS_reset),
        .LSU_req_valid      (LSU_req_valid),
        .LSU_req_ready      (LSU_req_ready),
        .LSU_req_write      (LSU_req_write),
        .LSU_req_funct3     (LSU_req_funct3),
        .LSU_req_address    (LSU_req_address),
        .LSU_req_wdata      (LSU_req_wdata),
        .LSU_resp_valid     (LSU_resp_valid),
        .LSU_resp_ready     (LSU_resp_ready),
        .LSU_resp_rdata     (LSU_resp_rdata),
        .LSU_resp_misaligned(LSU_resp_misaligned),
        .MEM_read_address   (MEM_read_address),
        .MEM_read_data      (MEM_read_data),
        .MEM_write_enable   (MEM_write_enable),
        .MEM_write_address  (MEM_write_address),
        .MEM_write_data     (MEM_write_data)
    );

    task automatic set_mem(input logic [31:0] a, input logic [31:0] d);
        @(negedge SYS_clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge SYS_clk);
        pre_en   = 1'b0;
    endtask

    // Offers one request; returns just after the accepting edge, so the next
    // negedge falls in cycle 1.
    task automatic do_req(input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int waited;
        @(negedge SYS_clk);
        LSU_req_valid   = 1'b1;
        LSU_req_write   = w;
        LSU_req_funct3  = f3;
        LSU_req_address = a;
        LSU_req_wdata   = d;
        waited = 0;
        while (!LSU_req_ready && waited < 20) begin
            @(negedge SYS_clk);
            waited++;
        end
        if (!LSU_req_ready) begin
            total++;
            bad++;
            $display("FAIL req_accept_timeout ready=%0b required=1", LSU_req_ready);
        end
        @(posedge SYS_clk);
        #1;
        LSU_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        SYS_reset = 1'b1;
        repeat (2) @(posedge SYS_clk);
        @(negedge SYS_clk);
        total++;
        if (MEM_write_enable !== 1'b0) begin
            bad++;
            $display("FAIL reset_we_during got=%0b want=0", MEM_write_enable);
        end
        SYS_reset = 1'b0;
        @(negedge SYS_clk);
        total++;
        if ({LSU_req_ready, LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=1000",
                     {LSU_req_ready, LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable});
        end
        total++;
        if (LSU_resp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_rdata got=%h want=00000000", LSU_resp_rdata);
        end
        total++;
        if ({MEM_read_address, MEM_write_address, MEM_write_data} !== 96'd0) begin
            bad++;
            $display("FAIL reset_mem_bus raddr=%h waddr=%h wdata=%h want=0",
                     MEM_read_address, MEM_write_address, MEM_write_data);
        end
        $display("reset: ready=%0b valid=%0b", LSU_req_ready, LSU_resp_valid);
    endtask

    task automatic test_sw;
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        @(negedge SYS_clk);
        total++;
        if ({MEM_write_enable, MEM_write_address, MEM_write_data, LSU_resp_valid}
            !== {1'b1, 32'h100, 32'hDEADBEEF, 1'b0}) begin
            bad++;
            $display("FAIL sw_cycle1 we=%0b addr=%h data=%h rv=%0b want we=1 addr=00000100 data=deadbeef rv=0",
                     MEM_write_enable, MEM_write_address, MEM_write_data, LSU_resp_valid);
        end
        @(negedge SYS_clk);
        total++;
        if ({LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable, LSU_resp_rdata}
            !== {3'b100, 32'd0}) begin
            bad++;
            $display("FAIL sw_cycle2 rv=%0b mis=%0b we=%0b rdata=%h want rv=1 mis=0 we=0 rdata=0",
                     LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable, LSU_resp_rdata);
        end
        @(negedge SYS_clk);
        total++;
        if (mem[8'd64] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL sw_mem got=%h want=deadbeef", mem[8'd64]);
        end
        $display("SW 0x100 <- deadbeef: mem=%h", mem[8'd64]);
    endtask

    task automatic test_sb;
        set_mem(32'h100, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h103, 32'h000000AA);
        @(negedge SYS_clk);
        total++;
        if ({MEM_write_enable, LSU_resp_valid, MEM_read_address} !== {2'b00, 32'h100}) begin
            bad++;
            $display("FAIL sb_cycle1 we=%0b rv=%0b raddr=%h want we=0 rv=0 raddr=00000100",
                     MEM_write_enable, LSU_resp_valid, MEM_read_address);
        end
        @(negedge SYS_clk);
        total++;
        if ({MEM_write_enable, MEM_write_address, MEM_write_data, LSU_resp_valid}
            !== {1'b1, 32'h100, 32'hAA223344, 1'b0}) begin
            bad++;
            $display("FAIL sb_cycle2 we=%0b addr=%h data=%h rv=%0b want we=1 addr=00000100 data=aa223344 rv=0",
                     MEM_write_enable, MEM_write_address, MEM_write_data, LSU_resp_valid);
        end
        @(negedge SYS_clk);
        total++;
        if ({LSU_resp_valid, LSU_resp_misaligned, LSU_resp_rdata} !== {2'b10, 32'd0}) begin
            bad++;
            $display("FAIL sb_cycle3 rv=%0b mis=%0b rdata=%h want rv=1 mis=0 rdata=0",
                     LSU_resp_valid, LSU_resp_misaligned, LSU_resp_rdata);
        end
        @(negedge SYS_clk);
        total++;
        if (mem[8'd64] !== 32'hAA223344) begin
            bad++;
            $display("FAIL sb_mem got=%h want=aa223344", mem[8'd64]);
        end
        $display("SB 0x103 <- aa: mem=%h", mem[8'd64]);
    endtask

    task automatic test_loads;
        logic [2:0]  f3  [8];
        logic [31:0] adr [8];
        logic [31:0] exp_v [8];
        f3[0] = 3'b000; adr[0] = 32'h102;      exp_v[0] = 32'hFFFFFF80;
        f3[1] = 3'b100; adr[1] = 32'h102;      exp_v[1] = 32'h00000080;
        f3[2] = 3'b001; adr[2] = 32'h102;      exp_v[2] = 32'h00001180;
        f3[3] = 3'b010; adr[3] = 32'h100;      exp_v[3] = 32'h11803344;
        f3[4] = 3'b000; adr[4] = 32'h101;      exp_v[4] = 32'h00000033;
        f3[5] = 3'b101; adr[5] = 32'h100;      exp_v[5] = 32'h00003344;
        f3[6] = 3'b001; adr[6] = 32'hFFFFFFFE; exp_v[6] = 32'hFFFF9ABC;
        f3[7] = 3'b010; adr[7] = 32'hFFFFFFFC; exp_v[7] = 32'h9ABC1234;
        set_mem(32'h100, 32'h11803344);
        set_mem(32'hFFFFFFFC, 32'h9ABC1234);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, f3[i], adr[i], 32'hFFFFFFFF);
            @(negedge SYS_clk);
            total++;
            if ({LSU_resp_valid, MEM_read_address} !== {1'b0, adr[i][31:2], 2'b00}) begin
                bad++;
                $display("FAIL load%0d_cycle1 rv=%0b raddr=%h want rv=0 raddr=%h",
                         i, LSU_resp_valid, MEM_read_address, {adr[i][31:2], 2'b00});
            end
            @(negedge SYS_clk);
            total++;
            if ({LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable, LSU_resp_rdata}
                !== {3'b100, exp_v[i]}) begin
                bad++;
                $display("FAIL load%0d_resp rv=%0b mis=%0b we=%0b rdata=%h want rv=1 mis=0 we=0 rdata=%h",
                         i, LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable,
                         LSU_resp_rdata, exp_v[i]);
            end
            $display("load f3=%b addr=%h -> rdata=%h", f3[i], adr[i], LSU_resp_rdata);
        end
    endtask

    task automatic test_misaligned;
        logic        w   [5];
        logic [2:0]  f3  [5];
        logic [31:0] adr [5];
        w[0] = 1'b1; f3[0] = 3'b001; adr[0] = 32'h101;
        w[1] = 1'b0; f3[1] = 3'b010; adr[1] = 32'h102;
        w[2] = 1'b0; f3[2] = 3'b011; adr[2] = 32'h100;
        w[3] = 1'b1; f3[3] = 3'b100; adr[3] = 32'h100;
        w[4] = 1'b0; f3[4] = 3'b101; adr[4] = 32'h103;
        for (int i = 0; i < 5; i++) begin
            do_req(w[i], f3[i], adr[i], 32'hFFFFFFFF);
            @(negedge SYS_clk);
            total++;
            if ({LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable, LSU_resp_rdata}
                !== {3'b110, 32'd0}) begin
                bad++;
                $display("FAIL err%0d_cycle1 rv=%0b mis=%0b we=%0b rdata=%h want rv=1 mis=1 we=0 rdata=0",
                         i, LSU_resp_valid, LSU_resp_misaligned, MEM_write_enable, LSU_resp_rdata);
            end
            $display("error req w=%0b f3=%b addr=%h -> mis=%0b", w[i], f3[i], adr[i],
                     LSU_resp_misaligned);
        end
        @(negedge SYS_clk);
        total++;
        if (mem[8'd64] !== 32'h11803344) begin
            bad++;
            $display("FAIL err_mem_untouched got=%h want=11803344", mem[8'd64]);
        end
    endtask

    task automatic test_backpressure;
        LSU_resp_ready = 1'b0;
        do_req(1'b0, 3'b010, 32'h100, 32'd0);
        @(negedge SYS_clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge SYS_clk);
            total++;
            if ({LSU_resp_valid, LSU_resp_misaligned, LSU_req_ready, LSU_resp_rdata}
                !== {3'b100, 32'h11803344}) begin
                bad++;
                $display("FAIL stall%0d rv=%0b mis=%0b rdy=%0b rdata=%h want rv=1 mis=0 rdy=0 rdata=11803344",
                         c, LSU_resp_valid, LSU_resp_misaligned, LSU_req_ready, LSU_resp_rdata);
            end
        end
        LSU_resp_ready = 1'b1;
        @(negedge SYS_clk);
        total++;
        if ({LSU_resp_valid, LSU_req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL stall_release rv=%0b rdy=%0b want rv=0 rdy=1", LSU_resp_valid, LSU_req_ready);
        end
        $display("backpressure LW 0x100: rdata=%h", LSU_resp_rdata);
    endtask

    task automatic test_reset_mid_wr;
        set_mem(32'h100, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h100, 32'h00000055);
        @(negedge SYS_clk);
        @(negedge SYS_clk);
        total++;
        if ({MEM_write_enable, MEM_write_data} !== {1'b1, 32'h11223355}) begin
            bad++;
            $display("FAIL rstwr_in_wr we=%0b data=%h want we=1 data=11223355",
                     MEM_write_enable, MEM_write_data);
        end
        SYS_reset = 1'b1;
        @(negedge SYS_clk);
        SYS_reset = 1'b0;
        total++;
        if ({LSU_req_ready, LSU_resp_valid, MEM_write_enable} !== 3'b100) begin
            bad++;
            $display("FAIL rstwr_state rdy=%0b rv=%0b we=%0b want rdy=1 rv=0 we=0",
                     LSU_req_ready, LSU_resp_valid, MEM_write_enable);
        end
        total++;
        if (mem[8'd64] !== 32'h11223344) begin
            bad++;
            $display("FAIL rstwr_mem got=%h want=11223344", mem[8'd64]);
        end
        $display("reset during SB write: mem=%h", mem[8'd64]);
    endtask

    initial begin
        test_reset;
        test_sw;
        test_sb;
        test_loads;
        test_misaligned;
        test_backpressure;
        test_reset_mid_wr;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
